seg7_scan_ctrl: RTL and testbench
=================================

# seg7_scan_ctrl

Time-multiplexed scan controller for the board's 4-digit seven-segment display. Holds four hex digits plus decimal points, decodes them internally, and drives the shared `io_seg` bus and `io_sel` digit enables one digit at a time, with an inter-digit blanking gap against ghosting. Sits between user logic (DIP switches, counters) and the top-level display pins. Updates are taken through a valid/ready handshake and applied only at frame boundaries so a frame never shows mixed old and new digits.

## Interface
- `DIV`, 100000: cycles per digit slot (1 ms at 100 MHz); legal `DIV >= 2`
- `BLANK`, 1000: blank cycles at the start of each slot; legal `1 <= BLANK < DIV`
- `clk` in 1: system clock, 100 MHz
- `rst` in 1: reset, asynchronous, active-high
- `load_valid` in 1: new display contents offered
- `load_ready` out 1: controller can accept a load
- `load_data` in 16: four hex nibbles; `[3:0]` is digit 0 (rightmost)
- `load_dp` in 4: decimal point per digit, 1 = lit
- `blank_en` in 1: 1 = force display dark
- `io_sel` out 4: digit enables, active-low; bit k = digit k
- `io_seg` out 8: segments, active-low; `[0..6]` = a..g, `[7]` = dp

## Operation
- Registers: active digits/dp (16+4), pending digits/dp (16+4) plus `pend_full`, digit index (2 bits), slot counter (`$clog2(DIV)` bits), state.
- States: `S_BLANK` (counter `0..BLANK-1`), `S_DRIVE` (counter `BLANK..DIV-1`).
  - `S_BLANK` -> `S_DRIVE` when counter = `BLANK-1`.
  - `S_DRIVE` -> `S_BLANK` when counter = `DIV-1`. The counter clears to 0 and the digit index increments mod 4 (3 wraps to 0).
- Outputs are registered; the edge that enters a state/digit also drives that state's output values.
  - `S_BLANK`: `io_sel`=1111, `io_seg`=FF.
  - `S_DRIVE`: `io_sel` has only bit k low; `io_seg` = ~{dp[k], hex7(nibble k)}.
  - `blank_en`=1 forces `io_sel`=1111 and `io_seg`=FF from the next edge. Scanning, loads and applies continue.
- Decode uses full hex, active-high g..a:
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71
- Handshake:
  - `load_ready` = ~`pend_full`.
  - Accept on `load_valid & load_ready`: capture into pending and set `pend_full`.
  - Apply on the edge where the index wraps 3->0: if `pend_full`, copy pending to active and clear `pend_full`.
- A load accepted on the same edge as an apply never has its data applied on that edge. It is applied at the next wrap.
- `load_data`/`load_dp` are ignored while `load_ready`=0. The source must hold them stable until acceptance.

## Timing
- Reset (async, immediate): `io_sel`=1111, `io_seg`=FF, `load_ready`=1, state `S_BLANK`, counter 0, index 0, active=0, dp=0, `pend_full`=0.
- First edge after reset release: counter 1. The first `S_DRIVE` output (digit 0) appears on the edge where the counter reaches `BLANK`.
- Slot = `DIV` cycles: `BLANK` dark, then `DIV-BLANK` lit. Frame = 4·`DIV` cycles.
- `load_ready` falls the edge after acceptance. It rises the edge of apply (visible the following cycle).
- Load-to-display latency: at most 4·`DIV`+`BLANK`+1 cycles.
- `blank_en` has 1 cycle of latency in each direction. On deassert, the current slot's state decides the output.
- Reset mid-`S_DRIVE` blanks outputs immediately. It discards pending and active contents.

## Test plan
Scenarios 1-4 and 6 use `DIV`=8, `BLANK`=2.
- Reset: assert `rst` mid-cycle -> `io_sel`=1111 and `io_seg`=FF immediately. `load_ready`=1. After release, the first digit-0 drive shows `io_seg`=C0 (digit 0 is 0).
- Periodicity: free-run 64 cycles -> each digit low exactly 6 cycles per 8. Order is 1110, 1101, 1011, 0111. Exactly 2 blank cycles between digits.
- Load 0x1234 with dp=0001 mid-frame -> no change until the wrap. After the wrap, the four digits in order 0..3 show 19, B0, A4, F9 (digit 0 has dp lit).
- Second load 0x5555 while `pend_full` -> not accepted and `load_ready`=0. The source holds it; it is accepted after the apply and shown one frame later as 92 on all digits.
- Load offered exactly on the wrap edge with `pend_full`=0 -> accepted, but the old value persists for that frame. The new value is shown from the next frame.
- `blank_en`=1 for 20 cycles during digit 2 drive -> outputs dark from the next edge. After release, the outputs resume in phase with an uninterrupted scan.

Source files
------------

// File: rtl/seg7_scan_ctrl_if.sv
// seg7_scan_ctrl_if
// Load channel between user logic and the seven-segment scan controller.
// Handshake: a transfer happens on a rising clk edge where load_valid and
// load_ready are both 1. The source raises load_valid with load_data and
// load_dp and holds all three stable until that edge. load_ready may drop
// while a load is offered. A source that is not offering keeps load_valid
// at 0.
//   load_valid : source -> sink, new display contents offered
//   load_ready : sink -> source, controller can accept a load
//   load_data  : source -> sink, four hex nibbles, [3:0] is digit 0 (rightmost)
//   load_dp    : source -> sink, decimal point per digit, 1 = lit
interface seg7_scan_ctrl_if;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_data;
    logic [3:0]  load_dp;

    modport master (
        output load_valid,
        output load_data,
        output load_dp,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        input  load_dp,
        output load_ready
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
// Scan controller for a 4-digit multiplexed seven-segment display. The
// controller holds four hex digits and their decimal points. It drives the
// digits one at a time. Each slot starts with a blanking gap, which stops
// ghosting between digits. A new load is staged in a pending register. The
// pending value is copied to the active register only where digit 3 wraps
// back to digit 0, so each frame shows one consistent value.
// Ports:
//   clk         : system clock
//   rst         : asynchronous active-high reset
//   load        : load channel (slave side), valid/ready handshake
//   blank_en    : 1 = force the display dark (registered, 1 cycle latency)
//   io_sel      : digit enables, active-low, bit k = digit k
//   io_seg      : segments, active-low, [6:0] = g..a, [7] = dp
//   dbg_state_o : current scan state (0 = blank gap, 1 = drive)
module seg7_scan_ctrl #(
    parameter int DIV   = 100000,  // cycles per digit slot, >= 2
    parameter int BLANK = 1000     // dark cycles at slot start, 1..DIV-1
) (
    input  logic              clk,
    input  logic              rst,
    seg7_scan_ctrl_if.slave   load,
    input  logic              blank_en,
    output logic [3:0]        io_sel,
    output logic [7:0]        io_seg,
    output logic              dbg_state_o
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_DRIVE = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] act_data_q, act_data_d;
    logic [3:0]  act_dp_q, act_dp_d;
    logic [15:0] pend_data_q, pend_data_d;
    logic [3:0]  pend_dp_q, pend_dp_d;
    logic        pend_full_q, pend_full_d;
    logic [3:0]  sel_q, sel_d;
    logic [7:0]  seg_q, seg_d;

    logic        accept;
    logic        slot_end;
    logic        wrap;
    logic [3:0]  nib;

    // Active-high g..a pattern for a full hex digit
    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign accept   = load.load_valid & ~pend_full_q;
    assign slot_end = (state_q == S_DRIVE) && (cnt_q == CW'(DIV - 1));
    assign wrap     = slot_end && (idx_q == 2'd3);

    // Scan sequencing
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        case (state_q)
            S_BLANK: begin
                if (cnt_q == CW'(BLANK - 1)) begin
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (slot_end) begin
                    state_d = S_BLANK;
                    cnt_d   = '0;
                    idx_d   = idx_q + 2'd1;
                end
            end
            default: begin
                state_d = S_BLANK;
                cnt_d   = '0;
            end
        endcase
    end

    // Pending/active staging. A load accepted on the wrap edge has
    // pend_full_q == 0 on that edge, so it is held over to the next wrap.
    always_comb begin
        act_data_d  = act_data_q;
        act_dp_d    = act_dp_q;
        pend_data_d = pend_data_q;
        pend_dp_d   = pend_dp_q;
        pend_full_d = pend_full_q;
        if (wrap && pend_full_q) begin
            act_data_d  = pend_data_q;
            act_dp_d    = pend_dp_q;
            pend_full_d = 1'b0;
        end
        if (accept) begin
            pend_data_d = load.load_data;
            pend_dp_d   = load.load_dp;
            pend_full_d = 1'b1;
        end
    end

    // Outputs are computed from the next state, so the edge that enters a
    // slot also drives that slot's pattern. The active value only changes at
    // a wrap. The wrap edge enters S_BLANK, so the current active value is
    // the one shown.
    always_comb begin
        nib   = act_data_q[{idx_d, 2'b00} +: 4];
        sel_d = 4'hF;
        seg_d = 8'hFF;
        if ((state_d == S_DRIVE) && !blank_en) begin
            sel_d = ~(4'b0001 << idx_d);
            seg_d = ~{act_dp_q[idx_d], hex7(nib)};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_BLANK;
            cnt_q       <= '0;
            idx_q       <= 2'd0;
            act_data_q  <= 16'h0000;
            act_dp_q    <= 4'h0;
            pend_data_q <= 16'h0000;
            pend_dp_q   <= 4'h0;
            pend_full_q <= 1'b0;
            sel_q       <= 4'hF;
            seg_q       <= 8'hFF;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            act_data_q  <= act_data_d;
            act_dp_q    <= act_dp_d;
            pend_data_q <= pend_data_d;
            pend_dp_q   <= pend_dp_d;
            pend_full_q <= pend_full_d;
            sel_q       <= sel_d;
            seg_q       <= seg_d;
        end
    end

    assign load.load_ready = ~pend_full_q;
    assign io_sel          = sel_q;
    assign io_seg          = seg_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
module tb_seg7_scan_ctrl;
    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 4 * DIV;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       blank_en = 1'b0;
    logic [3:0] io_sel;
    logic [7:0] io_seg;
    logic       dbg_state;

    seg7_scan_ctrl_if lif ();

    seg7_scan_ctrl #(.DIV(DIV), .BLANK(BLANK)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .load        (lif.slave),
        .blank_en    (blank_en),
        .io_sel      (io_sel),
        .io_seg      (io_seg),
        .dbg_state_o (dbg_state)
    );

    // clock/reset block
    always #5 clk = ~clk;

    // reference model: display position from the edge count, contents from
    // a pending/active pair updated at frame boundaries
    int          n;
    logic [15:0] m_act, m_pend;
    logic [3:0]  m_act_dp, m_pend_dp;
    logic        m_full;
    logic        m_acc;
    int          m_p, m_dig, m_s;
    logic [3:0]  m_nib;
    logic [12:0] m_e;
    logic [12:0] exp_q[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            n = 0;
            m_act = '0; m_pend = '0; m_act_dp = '0; m_pend_dp = '0; m_full = 1'b0;
            exp_q.delete();
        end else begin
            n = n + 1;
            m_acc = lif.load_valid && !m_full;
            if ((n % FRAME) == 0 && m_full) begin
                m_act = m_pend;
                m_act_dp = m_pend_dp;
                m_full = 1'b0;
            end
            if (m_acc) begin
                m_pend = lif.load_data;
                m_pend_dp = lif.load_dp;
                m_full = 1'b1;
            end
            m_p = n % FRAME;
            m_dig = m_p / DIV;
            m_s = m_p % DIV;
            if (m_s >= BLANK && !blank_en) begin
                m_nib = m_act[m_dig*4 +: 4];
                m_e = {!m_full, ~(4'b0001 << m_dig), ~{m_act_dp[m_dig], SEG_TAB[m_nib]}};
            end else begin
                m_e = {!m_full, 4'hF, 8'hFF};
            end
            exp_q.push_back(m_e);
        end
    end

    // scoreboard / monitor
    int          total = 0;
    int          bad = 0;
    logic        done = 1'b0;
    int          drv_timeout = 0;
    logic [12:0] got, want;

    always @(negedge clk) begin
        if (rst) begin
            total++;
            if (io_sel !== 4'hF || io_seg !== 8'hFF || lif.load_ready !== 1'b1) begin
                bad++;
                $display("FAIL reset_state: got ready=%b sel=%b seg=%h, want ready=1 sel=1111 seg=ff",
                         lif.load_ready, io_sel, io_seg);
            end
        end else if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got = {lif.load_ready, io_sel, io_seg};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL scan n=%0d: got ready=%b sel=%b seg=%h, want ready=%b sel=%b seg=%h",
                         n, got[12], got[11:8], got[7:0], want[12], want[11:8], want[7:0]);
            end
        end
        if (done) begin
            total++;
            if (drv_timeout != 0) begin
                bad++;
                $display("FAIL wait_bound: got %0d expired waits, want 0", drv_timeout);
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    // driver tasks
    task automatic send(input logic [15:0] d, input logic [3:0] dp);
        int budget;
        lif.load_valid = 1'b1;
        lif.load_data = d;
        lif.load_dp = dp;
        budget = 4 * FRAME;
        while (!lif.load_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (lif.load_ready) begin
            @(posedge clk);
            #1;
        end else begin
            drv_timeout++;
        end
        lif.load_valid = 1'b0;
    endtask

    task automatic wait_phase(input int ph);
        int budget;
        budget = FRAME + 2;
        @(negedge clk);
        while ((n % FRAME) != ph && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if ((n % FRAME) != ph) drv_timeout++;
    endtask

    initial begin
        lif.load_valid = 1'b0;
        lif.load_data = '0;
        lif.load_dp = '0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // free run, blank contents
        repeat (64) @(posedge clk);

        // mid-frame load, then a second load that must wait for the apply
        wait_phase(10);
        send(16'h1234, 4'b0001);
        send(16'h5555, 4'b0000);
        repeat (2 * FRAME) @(posedge clk);

        // load presented exactly on the wrap edge
        wait_phase(FRAME - 1);
        send(16'h9ABC, 4'b0110);
        repeat (2 * FRAME + 4) @(posedge clk);

        // blanking during digit 2 drive
        wait_phase(2 * DIV + 3);
        blank_en = 1'b1;
        repeat (20) @(negedge clk);
        blank_en = 1'b0;
        repeat (2 * FRAME) @(posedge clk);

        // reset in the middle of a drive slot, with content loaded
        send(16'hDEF0, 4'b1111);
        repeat (FRAME) @(posedge clk);
        wait_phase(DIV + 4);
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        repeat (FRAME + 4) @(posedge clk);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 40)) @(posedge clk);
            #2;
            case ($urandom_range(0, 3))
                0, 1: send(16'($urandom()), 4'($urandom()));
                2: blank_en = ~blank_en;
                default: begin
                    send(16'($urandom()), 4'($urandom()));
                    send(16'($urandom()), 4'($urandom()));
                end
            endcase
        end
        blank_en = 1'b0;
        repeat (2 * FRAME + 4) @(posedge clk);
        #2 done = 1'b1;
    end
endmodule
